// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: clock glitch filter, 11-bit frame
// deserialiser with parity/framing/timeout checks, show-ahead byte FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                        CLK_clk_i,
    input  logic                        RST_rstn_i,
    input  logic                        ps2d_i,
    input  logic                        ps2c_i,
    input  logic                        rx_en_i,
    input  logic                        rd_en_i,
    input  logic                        clr_err_i,
    output logic [7:0]                  dout_o,
    output logic                        dout_perr_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        rx_done_tick_o,
    output logic                        frame_err_tick_o,
    output logic                        timeout_tick_o,
    output logic                        overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic [FILTER_LEN-1:0] flt_q, flt_d;
    logic                  f_q, f_d;
    logic                  fall;

    logic [1:0]    state_q, state_d;
    logic [3:0]    n_q, n_d;
    logic [10:0]   sr_q, sr_d;
    logic [TW-1:0] timer_q, timer_d;

    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic [8:0] din;
    logic [8:0] head;

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [8:0]  mem_q [FIFO_DEPTH];
    logic        ovf_q, ovf_d;

    // Filtered clock only moves once the whole window agrees.
    always_comb begin
        flt_d = {ps2c_i, flt_q[FILTER_LEN-1:1]};
        f_d   = f_q;
        if (&flt_q) begin
            f_d = 1'b1;
        end else if (~|flt_q) begin
            f_d = 1'b0;
        end
        fall = f_q & ~f_d;
    end

    always_comb begin
        state_d          = state_q;
        n_d              = n_q;
        sr_d             = sr_q;
        timer_d          = timer_q;
        timeout_tick_o   = 1'b0;
        frame_err_tick_o = 1'b0;
        push_req         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fall && rx_en_i) begin
                    sr_d    = {ps2d_i, sr_q[10:1]};
                    n_d     = 4'd9;
                    timer_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    sr_d    = {ps2d_i, sr_q[10:1]};
                    timer_d = '0;
                    if (n_q == 4'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    timeout_tick_o = 1'b1;
                    timer_d        = '0;
                    state_d        = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (sr_q[0] || !sr_q[10]) begin
                    frame_err_tick_o = 1'b1;
                end else begin
                    push_req = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign din     = {~^sr_q[9:1], sr_q[8:1]};
    assign count_o = wr_q - rd_q;
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == (AW+1)'(FIFO_DEPTH));
    assign pop     = rd_en_i & ~empty_o;
    // A pop in the same clock frees the slot, so a full FIFO still accepts.
    assign push_ok        = push_req & (~full_o | pop);
    assign rx_done_tick_o = push_ok;

    assign head        = mem_q[rd_q[AW-1:0]];
    assign dout_o      = empty_o ? 8'h00 : head[7:0];
    assign dout_perr_o = empty_o ? 1'b0 : head[8];
    assign overflow_o  = ovf_q;

    always_comb begin
        wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        ovf_d = ovf_q;
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (clr_err_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_clk_i) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge CLK_clk_i or negedge RST_rstn_i) begin
        if (!RST_rstn_i) begin
            flt_q   <= '0;
            f_q     <= 1'b0;
            state_q <= S_IDLE;
            n_q     <= '0;
            sr_q    <= '0;
            timer_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            flt_q   <= flt_d;
            f_q     <= f_d;
            state_q <= state_d;
            n_q     <= n_d;
            sr_q    <= sr_d;
            timer_q <= timer_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames driven bit by bit on the
// PS/2 pins, expected FIFO entries queued and compared on pop.
module tb_ps2_rx_fifo;

    localparam int L  = 4;
    localparam int D  = 4;
    localparam int TO = 100;
    localparam int H  = 10;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ps2d    = 1'b1;
    logic       ps2c    = 1'b1;
    logic       rx_en   = 1'b1;
    logic       rd_en   = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] dout;
    logic       dout_perr;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       done;
    logic       ferr;
    logic       tout;
    logic       ovf;

    ps2_rx_fifo #(
        .FILTER_LEN (L),
        .FIFO_DEPTH (D),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK_clk_i       (clk),
        .RST_rstn_i      (rst_n),
        .ps2d_i          (ps2d),
        .ps2c_i          (ps2c),
        .rx_en_i         (rx_en),
        .rd_en_i         (rd_en),
        .clr_err_i       (clr_err),
        .dout_o          (dout),
        .dout_perr_o     (dout_perr),
        .empty_o         (empty),
        .full_o          (full),
        .count_o         (count),
        .rx_done_tick_o  (done),
        .frame_err_tick_o(ferr),
        .timeout_tick_o  (tout),
        .overflow_o      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int to_cnt = 0;
    int done_at = 0;
    int to_at = 0;
    int edge_at = 0;
    logic [8:0] sb[$];

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_at = cyc;
        end
        if (ferr) ferr_cnt++;
        if (tout) begin
            to_cnt++;
            to_at = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [8:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_empty"}, 32'(empty), 32'd0);
            chk(tag, {dout_perr, dout}, 32'(e));
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
        end
    endtask

    // rd_chk pulses rd_en_i in the CHECK clock of the stop bit.
    task automatic send(input logic [7:0] d, input bit pflip,
                        input bit stop, input int nbits, input bit rd_chk);
        logic [10:0] f;
        logic [8:0]  e;
        f = {stop, (~^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            tick(2);
            ps2c = 1'b0;
            edge_at = cyc;
            for (int j = 0; j < H; j++) begin
                tick(1);
                if (rd_chk && i == 10) begin
                    rd_en = (j == L);
                    if (j == L) begin
                        e = sb.pop_front();
                        chk("rd_in_check_head", {dout_perr, dout}, 32'(e));
                    end
                end
            end
            ps2c = 1'b1;
            tick(H);
        end
        ps2d = 1'b1;
        tick(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int f0;
        int t0;
        tick(5);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        rst_n = 1'b1;
        tick(20);

        // T1 good frame, latency
        d0 = done_cnt;
        send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        sb.push_back({1'b0, 8'h1C});
        chk("t1_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_done_cyc", 32'(done_at), 32'(edge_at + L + 1));
        chk("t1_count", 32'(count), 32'd1);
        pop_chk("t1_data");

        // T2 parity error still pushed
        f0 = ferr_cnt;
        send(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        sb.push_back({1'b1, 8'h1C});
        chk("t2_ferr", 32'(ferr_cnt - f0), 32'd0);
        pop_chk("t2_data");

        // T3 bad stop bit
        d0 = done_cnt;
        f0 = ferr_cnt;
        send(8'h55, 1'b0, 1'b0, 11, 1'b0);
        chk("t3_ferr", 32'(ferr_cnt - f0), 32'd1);
        chk("t3_done", 32'(done_cnt - d0), 32'd0);
        chk("t3_empty", 32'(empty), 32'd1);

        // T4 timeout then recovery
        t0 = to_cnt;
        send(8'h3C, 1'b0, 1'b1, 5, 1'b0);
        tick(150);
        chk("t4_to", 32'(to_cnt - t0), 32'd1);
        chk("t4_to_cyc", 32'(to_at), 32'(edge_at + L + TO));
        chk("t4_empty", 32'(empty), 32'd1);
        send(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        sb.push_back({1'b0, 8'hF0});
        pop_chk("t4_data");

        // T5 overflow
        d0 = done_cnt;
        for (int k = 1; k <= 5; k++) begin
            send(8'(k), 1'b0, 1'b1, 11, 1'b0);
            if (k <= D) sb.push_back({1'b0, 8'(k)});
        end
        chk("t5_done", 32'(done_cnt - d0), 32'd4);
        chk("t5_full", 32'(full), 32'd1);
        chk("t5_count", 32'(count), 32'd4);
        chk("t5_ovf", 32'(ovf), 32'd1);
        for (int k = 0; k < D; k++) pop_chk("t5_pop");
        chk("t5_drained", 32'(empty), 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t5_clr", 32'(ovf), 32'd0);
        for (int k = 0; k < D; k++) begin
            send(8'h11 + 8'(k), 1'b0, 1'b1, 11, 1'b0);
            sb.push_back({1'b0, 8'h11 + 8'(k)});
        end
        chk("t5_full2", 32'(full), 32'd1);
        d0 = done_cnt;
        send(8'h15, 1'b0, 1'b1, 11, 1'b1);
        sb.push_back({1'b0, 8'h15});
        chk("t5_pp_done", 32'(done_cnt - d0), 32'd1);
        chk("t5_pp_ovf", 32'(ovf), 32'd0);
        chk("t5_pp_count", 32'(count), 32'd4);
        for (int k = 0; k < D; k++) pop_chk("t5_pop2");

        // T6 glitches, rx_en off, reset mid-frame
        d0 = done_cnt;
        t0 = to_cnt;
        for (int g = 1; g < L; g++) begin
            ps2c = 1'b0;
            tick(g);
            ps2c = 1'b1;
            tick(10);
        end
        tick(150);
        chk("t6_glitch_to", 32'(to_cnt - t0), 32'd0);
        rx_en = 1'b0;
        send(8'hAA, 1'b0, 1'b1, 11, 1'b0);
        rx_en = 1'b1;
        tick(150);
        chk("t6_rxen_done", 32'(done_cnt - d0), 32'd0);
        chk("t6_rxen_to", 32'(to_cnt - t0), 32'd0);
        chk("t6_rxen_empty", 32'(empty), 32'd1);
        send(8'h33, 1'b0, 1'b1, 11, 1'b0);
        chk("t6_pre_count", 32'(count), 32'd1);
        send(8'h44, 1'b0, 1'b1, 3, 1'b0);
        d0 = done_cnt;
        f0 = ferr_cnt;
        t0 = to_cnt;
        rst_n = 1'b0;
        tick(3);
        sb.delete();
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        tick(150);
        chk("t6_rst_ticks", 32'((done_cnt - d0) + (ferr_cnt - f0) + (to_cnt - t0)), 32'd0);
        send(8'h5A, 1'b0, 1'b1, 11, 1'b0);
        sb.push_back({1'b0, 8'h5A});
        chk("t6_done", 32'(done_cnt - d0), 32'd1);
        pop_chk("t6_data");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
